pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush controller for the 5-stage 32-bit RISC pipeline. Drives the load enables
//  of the PC and the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB), and the IF/ID flush
//  and ID/EX bubble controls. It resolves load-use hazards, taken-branch/call/ret redirects and
//  multi-cycle data-memory waits. It keeps saturating stall/flush performance counters.
// PARAMETERS
//  REG_ADDR_W   4    register-specifier width (16 architectural registers)
//  WAIT_CNT_W   4    width of memory-wait counter
//  MAX_MEM_WAIT 12   wait cycles before mem_timeout is raised (< 2**WAIT_CNT_W)
//  PERF_W       16   width of performance counters
// PORTS
//  clk           in   1           pipeline clock, all state updates on posedge
//  rst           in   1           synchronous, active-high reset
//  id_valid      in   1           decode stage holds a real instruction
//  id_rs1        in   REG_ADDR_W  decode source register 1
//  id_rs2        in   REG_ADDR_W  decode source register 2
//  id_uses_rs1   in   1           decode instruction reads rs1
//  id_uses_rs2   in   1           decode instruction reads rs2 (not immediate form)
//  ex_valid      in   1           execute stage holds a real instruction
//  ex_isld       in   1           execute instruction is a load
//  ex_rd         in   REG_ADDR_W  execute destination register
//  branch_taken  in   1           EX resolved redirect (beq/bgt taken, b, call, ret)
//  mem_req       in   1           EX/MEM instruction is ld or st
//  mem_ready     in   1           data memory completes the access this cycle
//  pc_en         out  1           PC load enable
//  if_id_en      out  1           IF/ID register load enable
//  id_ex_en      out  1           ID/EX register load enable
//  ex_mem_en     out  1           EX/MEM register load enable
//  mem_wb_en     out  1           MEM/WB register load enable
//  if_id_flush   out  1           load NOP into IF/ID
//  id_ex_bubble  out  1           load NOP (all is* flags 0) into ID/EX
//  mem_timeout   out  1           sticky: memory wait exceeded MAX_MEM_WAIT
//  stall_cycles  out  PERF_W      saturating count of cycles with pc_en=0
//  flush_count   out  PERF_W      saturating count of taken redirects
// BEHAVIOUR
//  - States: RUN, MEMWAIT. Reset -> RUN, wait_cnt=0, counters=0, mem_timeout=0.
//  - While rst=1: all *_en=0, if_id_flush=1, id_ex_bubble=1. The cycle after release is normal RUN.
//  - Control outputs are combinational from state and inputs (zero latency). Counters and state are registered.
//  - Priority in RUN, highest first:
//    1 mem_req & !mem_ready: go to MEMWAIT. All enables=0, no flush/bubble (entire pipe frozen).
//    2 branch_taken & ex_valid: all enables=1, if_id_flush=1, id_ex_bubble=1. flush_count++.
//      Kills the two wrong-path instructions. A load-use in the same cycle is ignored.
//    3 load-use: ex_valid & ex_isld & id_valid & ((id_uses_rs1 & id_rs1==ex_rd) |
//      (id_uses_rs2 & id_rs2==ex_rd)). pc_en=0, if_id_en=0, id_ex_en=1 with id_ex_bubble=1,
//      ex_mem_en=1, mem_wb_en=1. Exactly one bubble. Register 0 is compared like any other.
//    4 otherwise all enables=1, no flush/bubble.
//  - MEMWAIT: all enables=0. wait_cnt increments each cycle and saturates at MAX_MEM_WAIT.
//    On reaching MAX_MEM_WAIT, mem_timeout is set and stays set until rst; the block keeps waiting.
//    On mem_ready=1: that cycle is evaluated with the RUN priority rules 2-4 (rule 1 skipped),
//    next state is RUN, and wait_cnt is cleared.
//  - A branch_taken seen while frozen is not acted on until the branch advances (ex_mem_en=1).
//  - stall_cycles increments on every non-reset cycle with pc_en=0. Both counters hold at all-ones.
// STRUCTURE
//  - pipeline_ctrl_pkg: state enum (RUN, MEMWAIT), REG_ADDR_W default, NOP encoding constant.
//  - One sub-module, perf_sat_counter (PERF_W, sync rst, inc) -> instantiated twice.
//  - The hazard compare stays inline; no other hierarchy.
// TESTING
//  - Reset: hold rst 3 cycles -> enables 0, flush/bubble 1, counters 0.
//    First post-reset cycle with no hazards -> all enables 1.
//  - Load-use: ex_isld=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 -> exactly 1 cycle with pc_en=0,
//    if_id_en=0, id_ex_bubble=1. stall_cycles=1.
//  - Same, but id_uses_rs2=0 (immediate form) -> no stall.
//  - Redirect+load-use: branch_taken=1 with a matching load-use -> flush=1, bubble=1, pc_en=1.
//    flush_count=1, stall_cycles unchanged.
//  - Memory wait: mem_req=1, mem_ready low 4 cycles -> 4 frozen cycles, stall_cycles=4, back to RUN.
//    mem_ready low 12 cycles -> mem_timeout=1 sticky after the wait ends.
//  - Counter saturation: force 70000 stall cycles -> stall_cycles=16'hFFFF. Mid-MEMWAIT rst -> RUN, wait_cnt=0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
//   state_e         controller state (RUN / MEMWAIT)
//   REG_ADDR_W_DEF  default register-specifier width (16 architectural registers)
//   NOP_INSTR       instruction encoding loaded by a flush or bubble
package pipeline_ctrl_pkg;

   typedef enum logic [0:0] {
      StRun     = 1'b0,
      StMemWait = 1'b1
   } state_e;

   localparam int unsigned REG_ADDR_W_DEF = 4;
   localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;

endpackage

// File: rtl/perf_sat_counter.sv
// Saturating event counter for performance monitoring.
//   clk    clock, updates on posedge
//   rst    synchronous active-high reset, clears the count
//   inc    count one event this cycle
//   count  current value, holds at all-ones
module perf_sat_counter #(
   parameter int unsigned PERF_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inc,
   output logic [PERF_W-1:0] count
);

   logic [PERF_W-1:0] count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else if (inc && (count_q != '1)) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Control outputs are combinational from state and inputs; state, wait counter,
// timeout flag and performance counters are registered.
//   inputs : clk, rst (sync, active-high), decode operands (id_*), execute
//            producer info (ex_*), branch_taken, mem_req, mem_ready
//   outputs: pc_en and four pipeline-register load enables, if_id_flush,
//            id_ex_bubble, sticky mem_timeout, stall_cycles, flush_count
module pipeline_hazard_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int unsigned REG_ADDR_W   = REG_ADDR_W_DEF,
   parameter int unsigned WAIT_CNT_W   = 4,
   parameter int unsigned MAX_MEM_WAIT = 12,
   parameter int unsigned PERF_W       = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_uses_rs1,
   input  logic                  id_uses_rs2,
   input  logic                  ex_valid,
   input  logic                  ex_isld,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  branch_taken,
   input  logic                  mem_req,
   input  logic                  mem_ready,
   output logic                  pc_en,
   output logic                  if_id_en,
   output logic                  id_ex_en,
   output logic                  ex_mem_en,
   output logic                  mem_wb_en,
   output logic                  if_id_flush,
   output logic                  id_ex_bubble,
   output logic                  mem_timeout,
   output logic [PERF_W-1:0]     stall_cycles,
   output logic [PERF_W-1:0]     flush_count
);

   localparam logic [WAIT_CNT_W-1:0] MaxWait = WAIT_CNT_W'(MAX_MEM_WAIT);

   state_e                state_q, state_d;
   logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic                  timeout_q, timeout_d;

   logic load_use;
   logic redirect;
   logic resolve;
   logic stall_inc;
   logic flush_inc;

   // Register 0 is not special: a load to r0 still stalls a dependent reader.
   assign load_use = ex_valid & ex_isld & id_valid &
                     ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                      (id_uses_rs2 & (id_rs2 == ex_rd)));
   assign redirect = branch_taken & ex_valid;

   always_comb begin
      pc_en        = 1'b1;
      if_id_en     = 1'b1;
      id_ex_en     = 1'b1;
      ex_mem_en    = 1'b1;
      mem_wb_en    = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      state_d      = state_q;
      wait_cnt_d   = wait_cnt_q;
      timeout_d    = timeout_q;
      resolve      = 1'b0;

      if (rst) begin
         pc_en        = 1'b0;
         if_id_en     = 1'b0;
         id_ex_en     = 1'b0;
         ex_mem_en    = 1'b0;
         mem_wb_en    = 1'b0;
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
      end else begin
         unique case (state_q)
            StRun: begin
               if (mem_req && !mem_ready) begin
                  state_d    = StMemWait;
                  // The detecting cycle is the first frozen cycle of the wait.
                  wait_cnt_d = WAIT_CNT_W'(1);
               end else begin
                  resolve = 1'b1;
               end
            end
            StMemWait: begin
               if (mem_ready) begin
                  resolve    = 1'b1;
                  state_d    = StRun;
                  wait_cnt_d = '0;
               end else if (wait_cnt_q != MaxWait) begin
                  wait_cnt_d = wait_cnt_q + 1'b1;
               end
            end
            default: state_d = StRun;
         endcase

         if (!resolve) begin
            // Whole pipe frozen; any redirect or load-use is re-evaluated once it advances.
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
         end else if (redirect) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
         end else if (load_use) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
         end

         if (wait_cnt_d == MaxWait) begin
            timeout_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StRun;
         wait_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         timeout_q  <= timeout_d;
      end
   end

   assign mem_timeout = timeout_q;
   assign stall_inc   = ~rst & ~pc_en;
   assign flush_inc   = ~rst & resolve & redirect;

   perf_sat_counter #(
      .PERF_W (PERF_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (stall_inc),
      .count (stall_cycles)
   );

   perf_sat_counter #(
      .PERF_W (PERF_W)
   ) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (flush_inc),
      .count (flush_count)
   );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid, id_uses_rs1, id_uses_rs2;
   logic [3:0] id_rs1, id_rs2, ex_rd;
   logic       ex_valid, ex_isld, branch_taken, mem_req, mem_ready;
   logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_bubble;
   logic       mem_timeout;
   logic [15:0] stall_cycles, flush_count;
   logic [6:0]  ctl;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .id_valid     (id_valid),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_uses_rs1  (id_uses_rs1),
      .id_uses_rs2  (id_uses_rs2),
      .ex_valid     (ex_valid),
      .ex_isld      (ex_isld),
      .ex_rd        (ex_rd),
      .branch_taken (branch_taken),
      .mem_req      (mem_req),
      .mem_ready    (mem_ready),
      .pc_en        (pc_en),
      .if_id_en     (if_id_en),
      .id_ex_en     (id_ex_en),
      .ex_mem_en    (ex_mem_en),
      .mem_wb_en    (mem_wb_en),
      .if_id_flush  (if_id_flush),
      .id_ex_bubble (id_ex_bubble),
      .mem_timeout  (mem_timeout),
      .stall_cycles (stall_cycles),
      .flush_count  (flush_count)
   );

   assign ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_bubble};

   typedef struct {
      bit       rst, id_valid, u1, u2, ex_valid, isld, br, req, rdy;
      bit [3:0] rs1, rs2, rd;
   } stim_t;

   int total = 0;
   int bad   = 0;

   // Reference model: counts of events, not a copy of the controller's state machine.
   bit       m_waiting;     // a memory access is outstanding after a frozen cycle
   int       m_frozen_run;  // consecutive frozen memory cycles in the current wait
   bit       m_tout;
   int       m_stall, m_flush;
   bit       e_frozen, e_redirect;
   logic [6:0] exp_ctl;

   localparam logic [6:0] CtlReset  = 7'b0000011;
   localparam logic [6:0] CtlFrozen = 7'b0000000;
   localparam logic [6:0] CtlFlush  = 7'b1111111;
   localparam logic [6:0] CtlLdUse  = 7'b0011101;
   localparam logic [6:0] CtlNormal = 7'b1111100;

   function automatic stim_t idle();
      stim_t s;
      s = '{default: 0};
      s.rdy = 1;
      return s;
   endfunction

   task automatic apply(input stim_t s);
      rst = s.rst; id_valid = s.id_valid; id_uses_rs1 = s.u1; id_uses_rs2 = s.u2;
      id_rs1 = s.rs1; id_rs2 = s.rs2; ex_valid = s.ex_valid; ex_isld = s.isld;
      ex_rd = s.rd; branch_taken = s.br; mem_req = s.req; mem_ready = s.rdy;
   endtask

   function automatic void model_eval();
      bit lu;
      lu = ex_valid && ex_isld && id_valid &&
           ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
      e_frozen   = !rst && !mem_ready && (m_waiting || mem_req);
      e_redirect = !rst && !e_frozen && branch_taken && ex_valid;
      if (rst)             exp_ctl = CtlReset;
      else if (e_frozen)   exp_ctl = CtlFrozen;
      else if (e_redirect) exp_ctl = CtlFlush;
      else if (lu)         exp_ctl = CtlLdUse;
      else                 exp_ctl = CtlNormal;
   endfunction

   function automatic void model_commit();
      if (rst) begin
         m_waiting = 0; m_frozen_run = 0; m_tout = 0; m_stall = 0; m_flush = 0;
      end else begin
         if (!exp_ctl[6] && m_stall < 65535) m_stall++;
         if (e_redirect && m_flush < 65535) m_flush++;
         if (e_frozen) begin
            m_waiting = 1;
            m_frozen_run++;
            if (m_frozen_run >= 12) m_tout = 1;
         end else begin
            m_waiting = 0;
            m_frozen_run = 0;
         end
      end
   endfunction

   task automatic test_reset();
      stim_t s;
      s = idle();
      s.rst = 1;
      for (int i = 0; i < 3; i++) begin
         apply(s); #2; model_eval();
         total++;
         if (ctl !== exp_ctl) begin
            bad++; $display("FAIL reset_ctl cyc%0d: got %b want %b", i, ctl, exp_ctl);
         end
         total++;
         if (stall_cycles !== 16'd0 || flush_count !== 16'd0 || mem_timeout !== 1'b0) begin
            bad++; $display("FAIL reset_cnt cyc%0d: got s=%0d f=%0d t=%b want 0 0 0",
                            i, stall_cycles, flush_count, mem_timeout);
         end
         @(posedge clk); model_commit(); #1;
      end
      apply(idle()); #2; model_eval();
      total++;
      if (ctl !== CtlNormal) begin
         bad++; $display("FAIL post_reset_run: got %b want %b", ctl, CtlNormal);
      end
      @(posedge clk); model_commit(); #1;
   endtask

   task automatic run_seq(input string name, input stim_t seq[$]);
      foreach (seq[i]) begin
         apply(seq[i]); #2; model_eval();
         total++;
         if (ctl !== exp_ctl) begin
            bad++; $display("FAIL %s_ctl step%0d: got %b want %b", name, i, ctl, exp_ctl);
         end
         total++;
         if (stall_cycles !== 16'(m_stall) || flush_count !== 16'(m_flush) ||
             mem_timeout !== m_tout) begin
            bad++; $display("FAIL %s_cnt step%0d: got s=%0d f=%0d t=%b want s=%0d f=%0d t=%b",
                            name, i, stall_cycles, flush_count, mem_timeout,
                            m_stall, m_flush, m_tout);
         end
         @(posedge clk); model_commit(); #1;
      end
   endtask

   task automatic test_load_use();
      stim_t q[$];
      stim_t s;
      int s0;
      s0 = m_stall;
      s = idle();
      s.ex_valid = 1; s.isld = 1; s.rd = 5; s.id_valid = 1; s.rs2 = 5; s.u2 = 1; s.rs1 = 3; s.u1 = 1;
      q.push_back(s);
      q.push_back(idle());                 // bubble now in EX
      s.u2 = 0; q.push_back(s);            // immediate form: no dependency
      s.rs1 = 0; s.rd = 0; q.push_back(s); // r0 dependency still stalls
      q.push_back(idle());
      run_seq("load_use", q);
      total++;
      if (stall_cycles !== 16'(s0 + 2)) begin
         bad++; $display("FAIL load_use_stalls: got %0d want %0d", stall_cycles, s0 + 2);
      end
   endtask

   task automatic test_redirect();
      stim_t q[$];
      stim_t s;
      int f0;
      f0 = m_flush;
      s = idle();
      s.ex_valid = 1; s.isld = 1; s.rd = 7; s.id_valid = 1; s.rs1 = 7; s.u1 = 1; s.br = 1;
      q.push_back(s);
      q.push_back(idle());
      s.isld = 0; s.br = 1; s.ex_valid = 0; q.push_back(s); // not valid: no redirect
      q.push_back(idle());
      run_seq("redirect", q);
      total++;
      if (flush_count !== 16'(f0 + 1)) begin
         bad++; $display("FAIL redirect_count: got %0d want %0d", flush_count, f0 + 1);
      end
   endtask

   task automatic test_mem_wait(input int lows, input bit with_branch);
      stim_t q[$];
      stim_t s;
      s = idle();
      s.req = 1; s.rdy = 0; s.br = with_branch; s.ex_valid = with_branch;
      for (int i = 0; i < lows; i++) q.push_back(s);
      s.rdy = 1; q.push_back(s);
      q.push_back(idle());
      q.push_back(idle());
      run_seq($sformatf("mem_wait%0d", lows), q);
   endtask

   task automatic test_mid_wait_reset();
      stim_t q[$];
      stim_t s;
      s = idle(); s.req = 1; s.rdy = 0;
      for (int i = 0; i < 8; i++) q.push_back(s);
      s.rst = 1; q.push_back(s);
      s.rst = 0;
      for (int i = 0; i < 11; i++) q.push_back(s);
      q.push_back(idle());
      q.push_back(idle());
      run_seq("mid_wait_rst", q);
   endtask

   task automatic test_random();
      stim_t q[$];
      stim_t s;
      for (int i = 0; i < 400; i++) begin
         s.rst = ($urandom_range(0, 59) == 0);
         s.id_valid = $urandom_range(0, 3) != 0;
         s.u1 = $urandom; s.u2 = $urandom;
         s.rs1 = 4'($urandom_range(0, 3)); s.rs2 = 4'($urandom_range(0, 3));
         s.rd = 4'($urandom_range(0, 3));
         s.ex_valid = $urandom_range(0, 3) != 0;
         s.isld = $urandom; s.br = ($urandom_range(0, 4) == 0);
         s.req = ($urandom_range(0, 3) == 0);
         s.rdy = $urandom_range(0, 9) < 7;
         q.push_back(s);
      end
      run_seq("random", q);
   endtask

   task automatic test_saturation();
      stim_t s;
      s = idle(); s.req = 1; s.rdy = 0;
      apply(s);
      for (int i = 0; i < 70000; i++) begin
         #2; model_eval();
         @(posedge clk); model_commit(); #1;
      end
      apply(idle()); #2; model_eval();
      total++;
      if (stall_cycles !== 16'hFFFF) begin
         bad++; $display("FAIL stall_saturate: got %h want ffff", stall_cycles);
      end
      total++;
      if (mem_timeout !== 1'b1 || ctl !== CtlNormal) begin
         bad++; $display("FAIL saturate_exit: got t=%b ctl=%b want t=1 ctl=%b",
                         mem_timeout, ctl, CtlNormal);
      end
      @(posedge clk); model_commit(); #1;
      run_seq("after_sat", '{idle(), idle()});
   endtask

   initial begin
      stim_t s;
      s = idle(); s.rst = 1;
      apply(s);
      m_waiting = 0; m_frozen_run = 0; m_tout = 0; m_stall = 0; m_flush = 0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_load_use();
      test_redirect();
      test_mem_wait(4, 1'b0);
      test_mem_wait(11, 1'b1);
      test_mem_wait(12, 1'b0);
      test_mid_wait_reset();
      test_random();
      test_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
